// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts LATENCY wait
// states, commits byte-strobed stores at response entry and returns data or error.
module dmem_responder #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [3:0]      req_wstrb,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic [XLEN-1:0]   mem [DEPTH];

    // With LATENCY=0 the response is entered on the accept edge itself, so the
    // commit path must look at the live request rather than the captured one.
    logic              src_we;
    logic [XLEN-1:0]   src_addr;
    logic [XLEN-1:0]   src_wdata;
    logic [3:0]        src_wstrb;
    logic              src_err;
    logic [AW-1:0]     src_idx;
    logic              enter_resp;
    logic              mem_we;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        enter_resp   = 1'b0;

        src_we    = (state_q == IDLE) ? req_we    : we_q;
        src_addr  = (state_q == IDLE) ? req_addr  : addr_q;
        src_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
        src_wstrb = (state_q == IDLE) ? req_wstrb : wstrb_q;
        src_err   = (src_addr[1:0] != 2'b00) ||
                    ({2'b00, src_addr[XLEN-1:2]} >= XLEN'(DEPTH));
        src_idx   = src_addr[AW+1:2];

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            resp_err_d   = src_err;
            resp_rdata_d = (!src_we && !src_err) ? mem[src_idx] : '0;
        end
        mem_we = enter_resp && src_we && !src_err;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // NOTE: the word array has no reset; clearing it would forbid RAM inference
    // and its contents are defined only by stores.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (src_wstrb[i]) mem[src_idx][8*i +: 8] <= src_wdata[8*i +: 8];
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2, DEPTH=1024): handshakes, byte
// strobes, error decode, backpressure and asynchronous reset behaviour.
module tb_dmem_responder;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    logic            clk;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [3:0]      req_wstrb;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where resp_valid is first seen.
    task automatic wait_resp(output logic [31:0] rdata, output logic err, output int lat);
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) check("resp_timeout", 32'(resp_valid), 32'd1);
        rdata = resp_rdata;
        err   = resp_err;
    endtask

    // Full transaction with resp_ready held high; entered and left at a negedge in IDLE.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata,
                       output logic err, output int lat);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp(rdata, err, lat);
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_rdata",      resp_rdata,      32'd0);
        check("rst_err",        32'(resp_err),   32'd0);

        // Store then load, checking the wait-state count.
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        check("st_latency", 32'(lat), 32'(LATENCY));
        check("st_err",     32'(er),  32'd0);
        check("st_rdata",   rd,       32'd0);
        check("st_idle",    32'(req_ready), 32'd1);
        txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check("ld_rdata",   rd,       32'hDEADBEEF);
        check("ld_err",     32'(er),  32'd0);
        check("ld_latency", 32'(lat), 32'(LATENCY));

        // Partial store: lanes 0 and 2 only.
        txn(1'b1, 32'h10, 32'h11223344, 4'hF, rd, er, lat);
        txn(1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check("partial_rdata", rd, 32'h11BB33DD);

        // Misaligned load.
        txn(1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
        check("misalign_err",   32'(er), 32'd1);
        check("misalign_rdata", rd,      32'd0);

        // Last word is legal; one past it errors and changes nothing.
        txn(1'b1, 32'(4*(DEPTH-1)), 32'hCAFEF00D, 4'hF, rd, er, lat);
        check("last_st_err", 32'(er), 32'd0);
        txn(1'b1, 32'(4*DEPTH), 32'h12345678, 4'hF, rd, er, lat);
        check("oob_err",   32'(er), 32'd1);
        check("oob_rdata", rd,      32'd0);
        txn(1'b0, 32'(4*(DEPTH-1)), 32'h0, 4'h0, rd, er, lat);
        check("last_ld_rdata", rd,      32'hCAFEF00D);
        check("last_ld_err",   32'(er), 32'd0);

        // Backpressure with a competing request waiting.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp(rd, er, lat);
        check("bp_latency", 32'(lat), 32'(LATENCY));
        req_valid = 1'b1;
        req_addr  = 32'(4*(DEPTH-1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_rdata",      resp_rdata,      32'h11BB33DD);
            check("bp_busy",       32'(busy),       32'd1);
            check("bp_req_ready",  32'(req_ready),  32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_idle",  32'(req_ready),  32'd1);
        check("bp_release_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("bp_next_accepted", 32'(busy), 32'd1);
        req_valid = 1'b0;
        wait_resp(rd, er, lat);
        check("bp_next_rdata", rd, 32'hCAFEF00D);
        @(negedge clk);

        // Reset mid-WAIT drops a pending store.
        txn(1'b1, 32'h20, 32'h0BADCAFE, 4'hF, rd, er, lat);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h55;
        req_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #3;
        check("wait_pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("async_req_ready",  32'(req_ready),  32'd1);
        check("async_resp_valid", 32'(resp_valid), 32'd0);
        check("async_busy",       32'(busy),       32'd0);
        check("async_rdata",      resp_rdata,      32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_valid", 32'(resp_valid), 32'd0);
        end
        reset = 1'b0;
        txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        check("wait_rst_kept", rd, 32'h0BADCAFE);

        // Reset during RESP keeps the committed store.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h24;
        req_wdata  = 32'h77;
        req_wstrb  = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp(rd, er, lat);
        reset = 1'b1;
        #1;
        check("resp_rst_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        reset      = 1'b0;
        resp_ready = 1'b1;
        txn(1'b0, 32'h24, 32'h0, 4'h0, rd, er, lat);
        check("resp_rst_kept", rd, 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
